// File: rtl/spi_slave_regfile_if.sv
// SPI pins and register-bank outputs of spi_slave_regfile, grouped for port connection.
interface spi_slave_regfile_if #(
  parameter int unsigned NREGS = 8
);
  logic                 sck_i;
  logic                 ss_i;
  logic                 mosi_i;
  logic                 miso_o;
  logic [8*NREGS-1:0]   regs_o;
  logic                 wr_stb_o;
  logic [2:0]           wr_adr_o;

  modport master (
    output sck_i, ss_i, mosi_i,
    input  miso_o, regs_o, wr_stb_o, wr_adr_o
  );

  modport slave (
    input  sck_i, ss_i, mosi_i,
    output miso_o, regs_o, wr_stb_o, wr_adr_o
  );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave exposing a small byte-addressed register bank; serial inputs are
// oversampled on the system clock and edge-detected after a 2-flop synchronizer.
module spi_slave_regfile #(
  parameter int unsigned NREGS       = 8,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5,
  parameter logic [7:0]  RESET_VAL   = 8'h00
) (
  input logic                clk_i,
  input logic                rst_i,
  spi_slave_regfile_if.slave bus
);
  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t        state;
  logic [1:0]    sck_sync, ss_sync, mosi_sync;
  logic          sck_d, ss_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_sh, tx_sh;
  logic [AW-1:0] adr;
  logic          is_read, load_pend;
  logic [7:0]    regs [NREGS];
  logic          wr_stb;
  logic [2:0]    wr_adr;

  logic       sck_rise, sck_fall, ss_rise, ss_fall;
  logic [7:0] rx_byte;

  assign sck_rise = sck_sync[1] & ~sck_d;
  assign sck_fall = ~sck_sync[1] & sck_d;
  assign ss_rise  = ss_sync[1] & ~ss_d;
  assign ss_fall  = ~ss_sync[1] & ss_d;
  assign rx_byte  = {rx_sh[6:0], mosi_sync[1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      sck_sync  <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      // ss history resets low so a frame already in progress cannot look like a
      // fresh falling edge; a real high-then-low is needed before CMD is entered.
      ss_sync   <= '0;
      ss_d      <= 1'b0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      adr       <= '0;
      is_read   <= 1'b0;
      load_pend <= 1'b0;
      wr_stb    <= 1'b0;
      wr_adr    <= '0;
      for (int unsigned k = 0; k < NREGS; k++) regs[k] <= RESET_VAL;
    end else begin
      sck_sync  <= {sck_sync[0], bus.sck_i};
      ss_sync   <= {ss_sync[0], bus.ss_i};
      mosi_sync <= {mosi_sync[0], bus.mosi_i};
      sck_d     <= sck_sync[1];
      ss_d      <= ss_sync[1];
      wr_stb    <= 1'b0;

      if (ss_rise) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        tx_sh     <= '0;
        load_pend <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) begin
              state     <= CMD;
              tx_sh     <= STATUS_BYTE;
              bit_cnt   <= '0;
              load_pend <= 1'b0;
            end
          end
          CMD, DATA: begin
            if (sck_rise) begin
              rx_sh   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == CMD) begin
                  is_read   <= rx_byte[7];
                  adr       <= rx_byte[AW-1:0];
                  load_pend <= rx_byte[7];
                  state     <= DATA;
                end else if (is_read) begin
                  load_pend <= 1'b1;
                end else begin
                  regs[adr] <= rx_byte;
                  wr_stb    <= 1'b1;
                  wr_adr    <= 3'(adr);
                  adr       <= adr + 1'b1;
                end
              end
            end else if (sck_fall) begin
              // Read data is fetched on the falling edge closing each byte so the
              // MSB is on MISO before the next rising edge.
              if (load_pend) begin
                tx_sh     <= regs[adr];
                adr       <= adr + 1'b1;
                load_pend <= 1'b0;
              end else begin
                tx_sh <= {tx_sh[6:0], 1'b0};
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.miso_o   = tx_sh[7];
  assign bus.wr_stb_o = wr_stb;
  assign bus.wr_adr_o = wr_adr;

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
    assign bus.regs_o[8*g +: 8] = regs[g];
  end
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Randomized bench for spi_slave_regfile: a byte-level register model predicts
// strobes and MISO bytes, which independent monitors pop and compare.
module tb_spi_slave_regfile;
  localparam int unsigned NREGS = 8;
  localparam logic [7:0]  STATUS = 8'hA5;
  localparam logic [7:0]  RVAL   = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_slave_regfile_if #(.NREGS(NREGS)) bus ();

  spi_slave_regfile #(
    .NREGS(NREGS),
    .STATUS_BYTE(STATUS),
    .RESET_VAL(RVAL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct packed {logic [2:0] adr; logic [7:0] data;} wr_t;
  typedef struct packed {logic chk; logic [7:0] val;} rd_t;

  logic [7:0] model [NREGS];
  wr_t        exp_wr[$];
  rd_t        exp_miso[$];
  logic [7:0] tx_q[$];
  logic [7:0] dq[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [8*NREGS-1:0] model_flat();
    logic [8*NREGS-1:0] f;
    f = '0;
    for (int k = 0; k < NREGS; k++) f[8*k +: 8] = model[k];
    return f;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe monitor
  wr_t w;
  always @(negedge clk) begin
    if (bus.wr_stb_o === 1'b1) begin
      if (exp_wr.size() == 0) begin
        total++;
        $display("FAIL wr_stb_unexpected: got strobe adr %0d, expected none", bus.wr_adr_o);
      end else begin
        w = exp_wr.pop_front();
        check("wr_adr", 64'(bus.wr_adr_o), 64'(w.adr));
        check("wr_data", 64'(bus.regs_o[8*w.adr +: 8]), 64'(w.data));
      end
    end
  end

  // MISO monitor: assembles bytes as the master would, on SCK rising edges
  int         mcnt = 0;
  logic [7:0] mbits;
  rd_t        r;
  always @(posedge bus.sck_i or posedge bus.ss_i) begin
    if (bus.ss_i === 1'b1) mcnt = 0;
    else begin
      mbits = {mbits[6:0], bus.miso_o};
      mcnt++;
      if (mcnt == 8) begin
        mcnt = 0;
        if (exp_miso.size() == 0) begin
          total++;
          $display("FAIL miso_unexpected: got byte %0h, expected none", mbits);
        end else begin
          r = exp_miso.pop_front();
          if (r.chk) check("miso_byte", 64'(mbits), 64'(r.val));
        end
      end
    end
  end

  task automatic send_bit(input logic b, input int half);
    bus.mosi_i = b;
    wait_clk(half);
    bus.sck_i = 1'b1;
    wait_clk(half);
    bus.sck_i = 1'b0;
  endtask

  task automatic frame(input int half, input int partial_bits, input bit do_rst);
    logic [7:0] byt;
    bus.ss_i = 1'b0;
    for (int i = 0; i < tx_q.size(); i++) begin
      byt = tx_q[i];
      for (int b = 7; b >= 0; b--) begin
        send_bit(byt[b], half);
        if (do_rst && i == 1 && b == 4) begin
          rst = 1'b1;
          wait_clk(2);
          rst = 1'b0;
          for (int k = 0; k < NREGS; k++) model[k] = RVAL;
          check("rst_miso", 64'(bus.miso_o), 64'(0));
          check("rst_regs", 64'(bus.regs_o), 64'(model_flat()));
        end
      end
    end
    for (int b = 0; b < partial_bits; b++) send_bit(1'($urandom), half);
    wait_clk(half);
    bus.ss_i = 1'b1;
    wait_clk(half + 6);
    check("miso_idle", 64'(bus.miso_o), 64'(0));
    check("regs_after_frame", 64'(bus.regs_o), 64'(model_flat()));
  endtask

  task automatic write_frame(input int half, input int start);
    int a;
    tx_q = {};
    tx_q.push_back({1'b0, 4'($urandom), 3'(start)});
    exp_miso.push_back({1'b1, STATUS});
    for (int i = 0; i < dq.size(); i++) begin
      a = (start + i) % NREGS;
      model[a] = dq[i];
      exp_wr.push_back({3'(a), dq[i]});
      exp_miso.push_back({1'b0, 8'h00});
      tx_q.push_back(dq[i]);
    end
    frame(half, 0, 1'b0);
  endtask

  task automatic read_frame(input int half, input int start, input int n);
    tx_q = {};
    tx_q.push_back({1'b1, 4'($urandom), 3'(start)});
    exp_miso.push_back({1'b1, STATUS});
    for (int i = 0; i < n; i++) begin
      exp_miso.push_back({1'b1, model[(start + i) % NREGS]});
      tx_q.push_back(8'($urandom));
    end
    frame(half, 0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int halves[3] = '{4, 5, 16};
    int start, n;
    bus.sck_i  = 1'b0;
    bus.ss_i   = 1'b1;
    bus.mosi_i = 1'b0;
    for (int k = 0; k < NREGS; k++) model[k] = RVAL;
    wait_clk(4);
    check("reset_miso", 64'(bus.miso_o), 64'(0));
    check("reset_wr_stb", 64'(bus.wr_stb_o), 64'(0));
    check("reset_wr_adr", 64'(bus.wr_adr_o), 64'(0));
    check("reset_regs", 64'(bus.regs_o), 64'(model_flat()));
    rst = 1'b0;
    wait_clk(6);

    // Basic write then read-back
    dq = {8'h11, 8'h22};
    write_frame(4, 2);
    read_frame(4, 2, 2);

    // Address wrap
    dq = {8'hAA, 8'hBB};
    write_frame(4, 7);
    read_frame(4, 7, 3);

    // Abort mid data byte: partial byte discarded
    tx_q = {8'h04};
    exp_miso.push_back({1'b1, STATUS});
    frame(4, 5, 1'b0);
    dq = {8'h5C};
    write_frame(4, 4);
    read_frame(4, 3, 3);

    // Reset during byte 1 of a write; remaining frame ignored
    tx_q = {8'h01, 8'h33, 8'h44, 8'h55};
    exp_miso.push_back({1'b1, STATUS});
    exp_miso.push_back({1'b0, 8'h00});
    exp_miso.push_back({1'b1, 8'h00});
    exp_miso.push_back({1'b1, 8'h00});
    frame(4, 0, 1'b1);
    dq = {8'h9E, 8'h3D};
    write_frame(4, 1);
    read_frame(4, 0, 4);

    // Divider sweep with random traffic
    for (int h = 0; h < 3; h++) begin
      for (int rep = 0; rep < 2; rep++) begin
        start = int'($urandom_range(NREGS - 1, 0));
        n     = int'($urandom_range(5, 1));
        dq = {};
        for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
        write_frame(halves[h], start);
        read_frame(halves[h], int'($urandom_range(NREGS - 1, 0)), NREGS + 1);
      end
    end

    wait_clk(10);
    check("exp_wr_drained", 64'(exp_wr.size()), 64'(0));
    check("exp_miso_drained", 64'(exp_miso.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
